// File: rtl/led_matrix_scan_pwm.sv
// Frame-buffered ROWS x COLS multi-channel dot-matrix driver: time-multiplexed row scan
// with per-pixel PWM and row blanking, a built-in lamp test and a light-pen cursor overlay.
module led_matrix_scan_pwm #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int CH           = 2,
  parameter int BPP          = 4,
  parameter int PWM_DIV      = 4,
  parameter int BLANK_CYC    = 2,
  parameter int FLASH_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [CH*BPP-1:0]         wr_data,
  input  logic                      cursor_en,
  input  logic [$clog2(ROWS)-1:0]   cursor_row,
  input  logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [ROWS-1:0]           row_n,
  output logic [CH*COLS-1:0]        col,
  output logic                      frame_start,
  output logic                      test_done
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int DW    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int STEPS = 2 * CH;
  localparam int SW    = $clog2(STEPS);
  localparam int FW    = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  localparam logic [DW-1:0]  DIV_LAST   = DW'(PWM_DIV - 1);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
  localparam logic [SW-1:0]  STEP_LAST  = SW'(STEPS - 1);
  localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_CYCLES - 1);
  localparam logic [BPP-1:0] MAX_LEVEL  = '1;

  typedef enum logic {T_STEP, T_DONE} test_state_t;

  logic run_mode;
  logic test_mode;

  assign run_mode  = mode[1];
  assign test_mode = (mode == 2'b01);

  logic [CH*BPP-1:0] frame [ROWS][COLS];

  logic [DW-1:0]  div_cnt;
  logic [BPP-1:0] pwm_cnt;
  logic [RW-1:0]  row_cnt;

  test_state_t    t_state, t_state_next;
  logic [SW-1:0]  step_cnt, step_next;
  logic [FW-1:0]  flash_cnt, flash_next;

  logic [ROWS-1:0]    row_n_d;
  logic [CH*COLS-1:0] col_d;
  logic               frame_start_d;
  logic               test_done_d;
  logic [BPP-1:0]     level;
  logic               in_blank;

  // Frame buffer; clear takes priority over a same-cycle pixel write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < COLS; k++)
          frame[r][k] <= '0;
    end else if (clr) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < COLS; k++)
          frame[r][k] <= '0;
    end else if (wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS)) begin
      frame[wr_row][wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      row_cnt <= '0;
    end else if (!run_mode) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      row_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      if (pwm_cnt == MAX_LEVEL) begin
        pwm_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_state   <= T_STEP;
      step_cnt  <= '0;
      flash_cnt <= '0;
    end else begin
      t_state   <= t_state_next;
      step_cnt  <= step_next;
      flash_cnt <= flash_next;
    end
  end

  // Lamp-test sequencer: parked at step 0 whenever the mode is not TEST.
  always_comb begin
    t_state_next = t_state;
    step_next    = step_cnt;
    flash_next   = flash_cnt;
    if (!test_mode) begin
      t_state_next = T_STEP;
      step_next    = '0;
      flash_next   = '0;
    end else if (t_state == T_STEP) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_next = '0;
        if (step_cnt == STEP_LAST)
          t_state_next = T_DONE;
        else
          step_next = step_cnt + 1'b1;
      end else begin
        flash_next = flash_cnt + 1'b1;
      end
    end
  end

  assign in_blank = (int'(pwm_cnt) * PWM_DIV + int'(div_cnt)) < BLANK_CYC;

  always_comb begin
    row_n_d       = '1;
    col_d         = '0;
    frame_start_d = 1'b0;
    test_done_d   = 1'b0;
    level         = '0;
    if (run_mode) begin
      row_n_d[row_cnt] = 1'b0;
      frame_start_d    = (row_cnt == '0) && (pwm_cnt == '0) && (div_cnt == '0);
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < COLS; k++) begin
          // The cursor pixel overrides the buffer with full-scale red only.
          if (cursor_en && (cursor_row == row_cnt) && (cursor_col == CW'(k)))
            level = (c == 0) ? MAX_LEVEL : '0;
          else
            level = frame[row_cnt][k][c*BPP +: BPP];
          col_d[c*COLS + k] = !in_blank && (level > pwm_cnt);
        end
      end
    end else if (test_mode) begin
      if (t_state == T_DONE) begin
        test_done_d = 1'b1;
      end else begin
        row_n_d = '0;
        for (int c = 0; c < CH; c++)
          if ((int'(step_cnt) % CH) == c)
            col_d[c*COLS +: COLS] = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_n       <= '1;
      col         <= '0;
      frame_start <= 1'b0;
      test_done   <= 1'b0;
    end else begin
      row_n       <= row_n_d;
      col         <= col_d;
      frame_start <= frame_start_d;
      test_done   <= test_done_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_pwm.sv
// Self-checking bench for led_matrix_scan_pwm: directed scenarios plus randomized traffic,
// compared cycle by cycle against a time-based behavioural model of the matrix driver.
module tb_led_matrix_scan_pwm;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int CH        = 2;
  localparam int BPP       = 4;
  localparam int PWM_DIV   = 4;
  localparam int BLANK_CYC = 2;
  localparam int FLASH     = 16;
  localparam int DWELL     = (1 << BPP) * PWM_DIV;
  localparam int FRAME     = DWELL * ROWS;
  localparam int MAXLVL    = (1 << BPP) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          mode = 2'b00;
  logic                clr = 1'b0;
  logic                wr_en = 1'b0;
  logic [2:0]          wr_row = '0;
  logic [2:0]          wr_col = '0;
  logic [CH*BPP-1:0]   wr_data = '0;
  logic                cursor_en = 1'b0;
  logic [2:0]          cursor_row = '0;
  logic [2:0]          cursor_col = '0;
  logic [ROWS-1:0]     row_n;
  logic [CH*COLS-1:0]  col;
  logic                frame_start;
  logic                test_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_matrix_scan_pwm #(
    .ROWS(ROWS), .COLS(COLS), .CH(CH), .BPP(BPP), .PWM_DIV(PWM_DIV),
    .BLANK_CYC(BLANK_CYC), .FLASH_CYCLES(FLASH)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .clr(clr), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cursor_en(cursor_en), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .row_n(row_n), .col(col), .frame_start(frame_start), .test_done(test_done)
  );

  // Reference model: the display is a function of time spent in the current mode.
  logic [CH*BPP-1:0]  m_fb [ROWS][COLS];
  int                 run_t;
  int                 test_t;
  logic [ROWS-1:0]    exp_row_n;
  logic [CH*COLS-1:0] exp_col;
  logic               exp_fs;
  logic               exp_td;

  function automatic logic [ROWS-1:0] model_rows(input logic [1:0] md, input int rt, input int tt);
    logic [ROWS-1:0] v = '1;
    if (md[1]) v[(rt / DWELL) % ROWS] = 1'b0;
    else if (md == 2'b01 && (tt / FLASH) < 2*CH) v = '0;
    return v;
  endfunction

  function automatic logic [CH*COLS-1:0] model_cols(input logic [1:0] md, input int rt, input int tt,
                                                    input logic cen, input logic [2:0] crow,
                                                    input logic [2:0] ccol);
    logic [CH*COLS-1:0] v = '0;
    int r, d, p, lvl;
    if (md[1]) begin
      r = (rt / DWELL) % ROWS;
      d = rt % DWELL;
      p = d / PWM_DIV;
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < COLS; k++) begin
          if (cen && int'(crow) == r && int'(ccol) == k) lvl = (c == 0) ? MAXLVL : 0;
          else lvl = int'(m_fb[r][k][c*BPP +: BPP]);
          v[c*COLS + k] = (d >= BLANK_CYC) && (lvl > p);
        end
    end else if (md == 2'b01 && (tt / FLASH) < 2*CH) begin
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < COLS; k++)
          v[c*COLS + k] = (c == (tt / FLASH) % CH);
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < COLS; k++)
          m_fb[r][k] <= '0;
      run_t     <= 0;
      test_t    <= 0;
      exp_row_n <= '1;
      exp_col   <= '0;
      exp_fs    <= 1'b0;
      exp_td    <= 1'b0;
    end else begin
      exp_row_n <= model_rows(mode, run_t, test_t);
      exp_col   <= model_cols(mode, run_t, test_t, cursor_en, cursor_row, cursor_col);
      exp_fs    <= mode[1] && ((run_t % FRAME) == 0);
      exp_td    <= (mode == 2'b01) && ((test_t / FLASH) >= 2*CH);
      run_t     <= mode[1] ? run_t + 1 : 0;
      test_t    <= (mode == 2'b01) ? test_t + 1 : 0;
      if (clr) begin
        for (int r = 0; r < ROWS; r++)
          for (int k = 0; k < COLS; k++)
            m_fb[r][k] <= '0;
      end else if (wr_en) begin
        m_fb[wr_row][wr_col] <= wr_data;
      end
    end
  end

  task automatic write_pixel(input int r, input int k, input logic [CH*BPP-1:0] d);
    wr_row  = 3'(r);
    wr_col  = 3'(k);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (row_n !== 8'hFF || col !== 16'h0 || frame_start !== 1'b0 || test_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_async got row_n=%h col=%h fs=%b td=%b want FF/0000/0/0", row_n, col, frame_start, test_done);
    end
    repeat (3) @(negedge clk);
    total++;
    if (row_n !== 8'hFF || col !== 16'h0 || frame_start !== 1'b0 || test_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_held got row_n=%h col=%h fs=%b td=%b want FF/0000/0/0", row_n, col, frame_start, test_done);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (row_n !== 8'hFF || col !== 16'h0 || frame_start !== 1'b0 || test_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stop_after_reset got row_n=%h col=%h fs=%b td=%b want FF/0000/0/0", row_n, col, frame_start, test_done);
    end
  endtask

  task automatic test_scan_empty();
    int fs_cnt = 0;
    int fs_last = -1;
    int gap_bad = 0;
    mode = 2'b10;
    for (int i = 0; i < 2*FRAME + 76; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL scan_empty cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
      if (i == 3*DWELL + 10) begin
        total++;
        if (row_n !== 8'hF7) begin bad++; $display("[TB] FAIL row_walk_3 got row_n=%h want F7", row_n); end
      end
      if (i == 7*DWELL + 63) begin
        total++;
        if (row_n !== 8'h7F) begin bad++; $display("[TB] FAIL row_walk_7 got row_n=%h want 7F", row_n); end
      end
      if (i == FRAME) begin
        total++;
        if (row_n !== 8'hFE) begin bad++; $display("[TB] FAIL row_wrap got row_n=%h want FE", row_n); end
      end
      if (frame_start === 1'b1) begin
        if (fs_last >= 0 && (i - fs_last) != FRAME) gap_bad++;
        if (fs_last < 0 && i != 0) gap_bad++;
        fs_last = i;
        fs_cnt++;
      end
    end
    total++;
    if (fs_cnt != 3 || gap_bad != 0) begin
      bad++;
      $display("[TB] FAIL frame_start_period got pulses=%0d bad_gaps=%0d want pulses=3 bad_gaps=0", fs_cnt, gap_bad);
    end
    mode = 2'b00;
    @(negedge clk);
    total++;
    if (row_n !== 8'hFF || col !== 16'h0 || frame_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL run_to_stop got row_n=%h col=%h fs=%b want FF/0000/0", row_n, col, frame_start);
    end
  endtask

  task automatic test_pixel_pwm();
    int red = 0;
    int grn = 0;
    int other = 0;
    int dwell = 0;
    write_pixel(2, 3, 8'hF8);
    mode = 2'b10;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL pixel_pwm cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
      if (row_n === 8'hFB) begin
        dwell++;
        red += int'(col[3]);
        grn += int'(col[COLS+3]);
        if ((col & ~16'h0808) !== 16'h0) other++;
      end else if (col !== 16'h0) begin
        other++;
      end
    end
    total++;
    if (dwell != DWELL || red != 30 || grn != 58 || other != 0) begin
      bad++;
      $display("[TB] FAIL pixel_duty got dwell=%0d red=%0d green=%0d stray=%0d want 64/30/58/0", dwell, red, grn, other);
    end
    mode = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_live_write();
    int lit = 0;
    mode = 2'b10;
    for (int i = 0; i < 5*DWELL + 20; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL live_scan cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
    end
    wr_row = 3'd5; wr_col = 3'd0; wr_data = 8'hFF; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    total++;
    if (row_n !== 8'hDF || col[0] !== 1'b0 || col !== exp_col) begin
      bad++;
      $display("[TB] FAIL live_write_pre got row_n=%h col=%h want DF/%h", row_n, col, exp_col);
    end
    @(negedge clk);
    total++;
    if (col[0] !== 1'b1 || col[COLS] !== 1'b1 || col !== exp_col) begin
      bad++;
      $display("[TB] FAIL live_write_visible got col=%h want %h with bits 0 and 8 set", col, exp_col);
    end
    wr_row = 3'd5; wr_col = 3'd1; wr_data = 8'hFF; wr_en = 1'b1; clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clr = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL clr_scan cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
      if (i >= 2 && col !== 16'h0) lit++;
    end
    total++;
    if (lit != 0) begin
      bad++;
      $display("[TB] FAIL clr_beats_write got lit_cycles=%0d want 0", lit);
    end
    mode = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_lamp();
    logic [ROWS-1:0]    want_rn;
    logic [CH*COLS-1:0] want_col;
    logic               want_td;
    mode = 2'b01;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL lamp_seq cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
      if (i == 0 || i == 15 || i == 16 || i == 40 || i == 63 || i == 64 || i == 79) begin
        want_rn  = (i < 64) ? 8'h00 : 8'hFF;
        want_col = (i >= 64) ? 16'h0000 : (((i / 16) % 2) == 0 ? 16'h00FF : 16'hFF00);
        want_td  = (i >= 64);
        total++;
        if (row_n !== want_rn || col !== want_col || test_done !== want_td) begin
          bad++;
          $display("[TB] FAIL lamp_step cyc=%0d got %h/%h/%b want %h/%h/%b", i, row_n, col, test_done, want_rn, want_col, want_td);
        end
      end
    end
    mode = 2'b00;
    @(negedge clk);
    total++;
    if (test_done !== 1'b0 || row_n !== 8'hFF || col !== 16'h0) begin
      bad++;
      $display("[TB] FAIL lamp_leave_done got td=%b row_n=%h col=%h want 0/FF/0000", test_done, row_n, col);
    end
    mode = 2'b01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL lamp_reentry cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
    end
    total++;
    if (col !== 16'h00FF || row_n !== 8'h00) begin
      bad++;
      $display("[TB] FAIL lamp_step2 got row_n=%h col=%h want 00/00FF", row_n, col);
    end
    mode = 2'b00;
    @(negedge clk);
    total++;
    if (test_done !== 1'b0 || row_n !== 8'hFF || col !== 16'h0) begin
      bad++;
      $display("[TB] FAIL lamp_abort got td=%b row_n=%h col=%h want 0/FF/0000", test_done, row_n, col);
    end
    mode = 2'b01;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0 || i == 16) begin
        want_col = (i == 0) ? 16'h00FF : 16'hFF00;
        total++;
        if (row_n !== 8'h00 || col !== want_col || test_done !== 1'b0) begin
          bad++;
          $display("[TB] FAIL lamp_restart cyc=%0d got %h/%h/%b want 00/%h/0", i, row_n, col, test_done, want_col);
        end
      end
    end
    mode = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_cursor();
    int red = 0;
    int grn = 0;
    write_pixel(4, 6, 8'hF0);
    cursor_row = 3'd4; cursor_col = 3'd6; cursor_en = 1'b1;
    mode = 2'b10;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL cursor_on cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
      if (row_n === 8'hEF) begin
        red += int'(col[6]);
        grn += int'(col[COLS+6]);
      end
    end
    total++;
    if (red != 58 || grn != 0) begin
      bad++;
      $display("[TB] FAIL cursor_overlay got red=%0d green=%0d want 58/0", red, grn);
    end
    mode = 2'b00; cursor_en = 1'b0;
    @(negedge clk);
    red = 0; grn = 0;
    mode = 2'b10;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL cursor_off cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
      if (row_n === 8'hEF) begin
        red += int'(col[6]);
        grn += int'(col[COLS+6]);
      end
    end
    total++;
    if (red != 0 || grn != 58) begin
      bad++;
      $display("[TB] FAIL cursor_restore got red=%0d green=%0d want 0/58", red, grn);
    end
    mode = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lit = 0;
    mode = 2'b01;
    repeat (52) @(negedge clk);
    total++;
    if (col !== 16'hFF00 || row_n !== 8'h00) begin
      bad++;
      $display("[TB] FAIL test_step3 got row_n=%h col=%h want 00/FF00", row_n, col);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (row_n !== 8'hFF || col !== 16'h0 || frame_start !== 1'b0 || test_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_in_test got %h/%h/%b/%b want FF/0000/0/0", row_n, col, frame_start, test_done);
    end
    @(negedge clk);
    rst = 1'b0;
    mode = 2'b00;
    @(negedge clk);
    write_pixel(6, 1, 8'hFF);
    mode = 2'b10;
    for (int i = 0; i < 6*DWELL + 30; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL rst_run_scan cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
    end
    total++;
    if (row_n !== 8'hBF || col !== 16'h0202) begin
      bad++;
      $display("[TB] FAIL run_row6 got row_n=%h col=%h want BF/0202", row_n, col);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (row_n !== 8'hFF || col !== 16'h0 || frame_start !== 1'b0 || test_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_in_run got %h/%h/%b/%b want FF/0000/0/0", row_n, col, frame_start, test_done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      total++;
      if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
        bad++;
        $display("[TB] FAIL rst_rescan cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
      end
      if (col !== 16'h0) lit++;
    end
    total++;
    if (lit != 0) begin
      bad++;
      $display("[TB] FAIL buffer_cleared_by_rst got lit_cycles=%0d want 0", lit);
    end
    mode = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 14; s++) begin
      mode       = 2'($urandom_range(0, 3));
      if (s == 3) mode = 2'b01;
      cursor_en  = 1'($urandom_range(0, 1));
      cursor_row = 3'($urandom);
      cursor_col = 3'($urandom);
      len        = (s == 3) ? 100 : $urandom_range(40, 400);
      for (int i = 0; i < len; i++) begin
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_row  = 3'($urandom);
        wr_col  = 3'($urandom);
        wr_data = 8'($urandom);
        clr     = ($urandom_range(0, 149) == 0);
        @(negedge clk);
        total++;
        if (row_n !== exp_row_n || col !== exp_col || frame_start !== exp_fs || test_done !== exp_td) begin
          bad++;
          $display("[TB] FAIL random seg=%0d cyc=%0d mode=%b got %h/%h/%b/%b want %h/%h/%b/%b", s, i, mode, row_n, col, frame_start, test_done, exp_row_n, exp_col, exp_fs, exp_td);
        end
      end
    end
    wr_en = 1'b0;
    clr   = 1'b0;
    mode  = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting led_matrix_scan_pwm bench");
    #1;
    test_reset();
    test_scan_empty();
    test_pixel_pwm();
    test_live_write();
    test_lamp();
    test_cursor();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
